// File: rtl/leaf_pkt_pkg.sv
// Shared BFT packet definitions for the leaf stream transmitter: field layout,
// the reserved credit port, transmitter states and the packet builder.
`timescale 1ns/1ps
package leaf_pkt_pkg;

  localparam int PKT_W  = 49;
  localparam int PAY_W  = 32;
  localparam int LEAF_W = 5;
  localparam int PORT_W = 4;
  localparam int ADDR_W = 7;

  localparam int PAYLOAD_LSB = 0;
  localparam int ADDR_LSB    = PAYLOAD_LSB + PAY_W;
  localparam int PORT_LSB    = ADDR_LSB + ADDR_W;
  localparam int LEAF_LSB    = PORT_LSB + PORT_W;
  localparam int VALID_BIT   = LEAF_LSB + LEAF_W;

  localparam logic [PORT_W-1:0] CREDIT_PORT = '0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_PAUSE
  } tx_state_e;

  function automatic logic [PKT_W-1:0] make_packet(
    input logic [LEAF_W-1:0] leaf,
    input logic [PORT_W-1:0] port,
    input logic [ADDR_W-1:0] addr,
    input logic [PAY_W-1:0]  payload
  );
    logic [PKT_W-1:0] pkt;
    pkt = '0;
    pkt[VALID_BIT]                  = 1'b1;
    pkt[LEAF_LSB +: LEAF_W]         = leaf;
    pkt[PORT_LSB +: PORT_W]         = port;
    pkt[ADDR_LSB +: ADDR_W]         = addr;
    pkt[PAYLOAD_LSB +: PAY_W]       = payload;
    return pkt;
  endfunction

endpackage

// File: rtl/leaf_credit_counter.sv
// Credit tracker for the remote receive buffer: one credit per packet sent,
// returned credits added back, saturating at the buffer depth.
`timescale 1ns/1ps
module leaf_credit_counter #(
  parameter int CREDIT_INIT = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec,
  input  logic [7:0] ret,
  output logic [7:0] count,
  output logic       zero,
  output logic       err_ovf
);

  localparam logic [8:0] LIMIT = 9'(CREDIT_INIT);

  logic [8:0] sum;

  // A send is only ever granted with count > 0, so the subtraction cannot underflow.
  always_comb begin
    sum = {1'b0, count} - {8'd0, dec} + {1'b0, ret};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= LIMIT[7:0];
      err_ovf <= 1'b0;
    end else if (sum > LIMIT) begin
      count   <= LIMIT[7:0];
      err_ovf <= 1'b1;
    end else begin
      count   <= sum[7:0];
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/leaf_stream_tx.sv
// Packetizing transmitter: wraps user words into BFT packets for a fixed
// destination leaf/port, gated by receiver credits and link replay.
`timescale 1ns/1ps
module leaf_stream_tx
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int DEST_LEAF     = 2,
  parameter int DEST_PORT     = 1,
  parameter int CREDIT_INIT   = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic                    vld_user2interface,
  output logic                    ack_interface2user,
  output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
  input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
  input  logic                    resend,
  output logic [7:0]              credit_cnt,
  output logic                    err_credit_ovf
);

  localparam logic [NUM_LEAF_BITS-1:0] LEAF_ID = NUM_LEAF_BITS'(DEST_LEAF);
  localparam logic [NUM_PORT_BITS-1:0] PORT_ID = NUM_PORT_BITS'(DEST_PORT);

  tx_state_e                  state;
  logic                       credit_zero;
  logic                       send;
  logic                       credit_pkt;
  logic [7:0]                 ret_credits;
  logic [NUM_ADDR_BITS-1:0]   wr_addr;
  logic [PACKET_BITS-1:0]     dout_q;
  logic                       unused_bft_bits;

  // Replay outranks an empty credit pool; only RUN lets a word through.
  always_comb begin
    state = ST_RUN;
    if (resend) begin
      state = ST_PAUSE;
    end else if (credit_zero) begin
      state = ST_STALL;
    end
  end

  assign ack_interface2user = vld_user2interface & (state == ST_RUN);
  assign send               = ack_interface2user;

  assign credit_pkt  = din_leaf_bft2interface[VALID_BIT] &
                       (din_leaf_bft2interface[PORT_LSB +: PORT_W] == CREDIT_PORT);
  assign ret_credits = credit_pkt ? din_leaf_bft2interface[7:0] : 8'd0;
  assign unused_bft_bits = ^{din_leaf_bft2interface[PKT_W-2:PORT_LSB + PORT_W],
                             din_leaf_bft2interface[PORT_LSB-1:8]};

  leaf_credit_counter #(
    .CREDIT_INIT(CREDIT_INIT)
  ) u_credit (
    .clk     (clk),
    .reset   (reset),
    .dec     (send),
    .ret     (ret_credits),
    .count   (credit_cnt),
    .zero    (credit_zero),
    .err_ovf (err_credit_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q  <= '0;
      wr_addr <= '0;
    end else if (send) begin
      dout_q  <= make_packet(LEAF_ID, PORT_ID, wr_addr, din_leaf_user2interface);
      wr_addr <= wr_addr + 1'b1;
    end else begin
      dout_q  <= '0;
    end
  end

  // Nothing leaves the block while the link is replaying.
  assign dout_leaf_interface2bft = resend ? '0 : dout_q;

endmodule

// File: tb/tb_leaf_stream_tx.sv
// Randomized scoreboard bench for leaf_stream_tx against a queue/arithmetic
// model of the credit protocol.
`timescale 1ns/1ps
module tb_leaf_stream_tx;

  logic        clk;
  logic        reset;
  logic [31:0] din;
  logic        vld;
  logic        ack;
  logic [48:0] dout;
  logic [48:0] bft_in;
  logic        resend;
  logic [7:0]  credit_cnt;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [48:0] exp_q[$];
  logic        pend_valid = 1'b0;
  logic [48:0] pend_pkt   = '0;
  int          model_credit = 128;
  int          model_addr   = 0;
  logic        model_err    = 1'b0;

  leaf_stream_tx dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .dout_leaf_interface2bft (dout),
    .din_leaf_bft2interface  (bft_in),
    .resend                  (resend),
    .credit_cnt              (credit_cnt),
    .err_credit_ovf          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] data_pkt(input int addr, input logic [31:0] d);
    logic [6:0] a;
    a = 7'(addr);
    return {1'b1, 5'd2, 4'd1, a, d};
  endfunction

  function automatic logic [48:0] credit_pkt(input logic vbit, input logic [3:0] port, input logic [7:0] n);
    return {vbit, 5'd19, port, 7'd77, 24'hA5C3E1, n};
  endfunction

  // Monitor: every non-empty packet the DUT shows must be the oldest expected one.
  always @(negedge clk) begin
    if (!reset && dout != '0) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_pkt", {15'd0, dout}, 64'd0);
      end else begin
        check_output("pkt", {15'd0, dout}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic rs, input logic [48:0] bft);
    logic exp_ack;
    int   n;
    int   nxt;
    vld    = v;
    din    = d;
    resend = rs;
    bft_in = bft;
    if (pend_valid) begin
      if (!rs) exp_q.push_back(pend_pkt);
      pend_valid = 1'b0;
    end
    #1;
    exp_ack = v && (model_credit != 0) && !rs;
    check_output("ack", {63'd0, ack}, {63'd0, exp_ack});
    n = (bft[48] && bft[42:39] == 4'd0) ? int'(bft[7:0]) : 0;
    if (exp_ack) begin
      pend_valid = 1'b1;
      pend_pkt   = data_pkt(model_addr, d);
      model_addr = (model_addr + 1) % 128;
    end
    nxt = model_credit - (exp_ack ? 1 : 0) + n;
    if (nxt > 128) begin
      nxt       = 128;
      model_err = 1'b1;
    end
    model_credit = nxt;
    @(posedge clk);
    #1;
    check_output("credit_cnt", {56'd0, credit_cnt}, 64'(model_credit));
    check_output("err_ovf", {63'd0, err}, {63'd0, model_err});
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 32'd0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset  = 1'b1;
    vld    = 1'b0;
    din    = '0;
    resend = 1'b0;
    bft_in = '0;
    #2;
    check_output("reset_dout", {15'd0, dout}, 64'd0);
    check_output("reset_ack", {63'd0, ack}, 64'd0);
    check_output("reset_credit", {56'd0, credit_cnt}, 64'd128);
    check_output("reset_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Single word, then fill the receiver completely.
    apply_stimulus(1'b1, 32'hDEADBEEF, 1'b0, '0);
    check_output("single_credit", {56'd0, credit_cnt}, 64'd127);
    check_output("single_dout", {15'd0, dout}, {15'd0, 1'b1, 5'd2, 4'd1, 7'd0, 32'hDEADBEEF});
    for (int i = 1; i < 128; i++) apply_stimulus(1'b1, $urandom, 1'b0, '0);
    apply_stimulus(1'b1, 32'h12345678, 1'b0, '0);
    check_output("empty_dout", {15'd0, dout}, 64'd0);
    check_output("empty_credit", {56'd0, credit_cnt}, 64'd0);

    // Returns: ignored variants first, then a real port-0 return of 64.
    apply_stimulus(1'b1, 32'h1, 1'b0, credit_pkt(1'b1, 4'd3, 8'd50));
    apply_stimulus(1'b1, 32'h2, 1'b0, credit_pkt(1'b0, 4'd0, 8'd50));
    apply_stimulus(1'b1, 32'h3, 1'b0, credit_pkt(1'b1, 4'd0, 8'd64));
    check_output("return_credit", {56'd0, credit_cnt}, 64'd64);
    apply_stimulus(1'b1, 32'hCAFE0000, 1'b0, '0);
    check_output("wrap_dout", {15'd0, dout}, {15'd0, 1'b1, 5'd2, 4'd1, 7'd0, 32'hCAFE0000});

    // Drain to 10, then send and return 5 together.
    while (model_credit > 10) apply_stimulus(1'b1, $urandom, 1'b0, '0);
    apply_stimulus(1'b1, 32'h55, 1'b0, credit_pkt(1'b1, 4'd0, 8'd5));
    check_output("simul_credit", {56'd0, credit_cnt}, 64'd14);

    // Fill exactly to the limit, then one past it.
    apply_stimulus(1'b0, 32'd0, 1'b0, credit_pkt(1'b1, 4'd0, 8'd114));
    check_output("full_err", {63'd0, err}, 64'd0);
    apply_stimulus(1'b0, 32'd0, 1'b0, credit_pkt(1'b1, 4'd0, 8'd1));
    check_output("ovf_credit", {56'd0, credit_cnt}, 64'd128);
    check_output("ovf_err", {63'd0, err}, 64'd1);

    // Replay pause mid-stream.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, $urandom, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, $urandom, 1'b1, '0);
      check_output("resend_dout", {15'd0, dout}, 64'd0);
    end
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, $urandom, 1'b0, '0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic        rs;
      logic [48:0] b;
      v  = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 9) == 0);
      b  = '0;
      if ($urandom_range(0, 4) == 0) begin
        b = credit_pkt($urandom_range(0, 5) != 0,
                       ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                       8'($urandom_range(0, 40)));
      end
      apply_stimulus(v, $urandom, rs, b);
    end

    // Asynchronous reset with a packet on the output.
    apply_stimulus(1'b1, 32'h0BADF00D, 1'b0, '0);
    apply_stimulus(1'b1, 32'hFEEDFACE, 1'b0, '0);
    vld    = 1'b0;
    resend = 1'b0;
    bft_in = '0;
    if (pend_valid) begin
      check_output("pre_reset_dout", {15'd0, dout}, {15'd0, pend_pkt});
    end else begin
      check_output("pre_reset_dout", {15'd0, dout}, 64'd0);
    end
    #2 reset = 1'b1;
    #1;
    check_output("async_reset_dout", {15'd0, dout}, 64'd0);
    check_output("async_reset_credit", {56'd0, credit_cnt}, 64'd128);
    check_output("async_reset_err", {63'd0, err}, 64'd0);
    exp_q.delete();
    pend_valid   = 1'b0;
    model_credit = 128;
    model_addr   = 0;
    model_err    = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 32'h600DCAFE, 1'b0, '0);
    check_output("post_reset_dout", {15'd0, dout}, {15'd0, 1'b1, 5'd2, 4'd1, 7'd0, 32'h600DCAFE});
    apply_stimulus(1'b1, 32'h00000042, 1'b0, '0);
    idle_cycle();
    idle_cycle();
    check_output("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
